// File: rtl/tcb_arb_rr.sv
// Round-robin TCB arbiter: PN managers share one subordinate, with transfer
// locking and fixed-latency (DLY) response routing back to the issuing port.

module tcb_arb_rr_lane #(
    parameter int unsigned DW = 32
) (
    input  logic          sel_req,
    input  logic          sel_rsp,
    input  logic          m_rdy,
    input  logic [DW-1:0] m_rdt,
    input  logic          m_err,
    output logic          s_rdy,
    output logic [DW-1:0] s_rdt,
    output logic          s_err
);
    assign s_rdy = sel_req & m_rdy;
    assign s_rdt = sel_rsp ? m_rdt : '0;
    assign s_err = sel_rsp & m_err;
endmodule

module tcb_arb_rr #(
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned BW  = DW/8,
    parameter int unsigned PN  = 3,
    parameter int unsigned DLY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PN-1:0]          s_vld,
    input  logic [PN-1:0]          s_lck,
    input  logic [PN-1:0]          s_wen,
    input  logic [PN-1:0][AW-1:0]  s_adr,
    input  logic [PN-1:0][BW-1:0]  s_ben,
    input  logic [PN-1:0][DW-1:0]  s_wdt,
    output logic [PN-1:0]          s_rdy,
    output logic [PN-1:0][DW-1:0]  s_rdt,
    output logic [PN-1:0]          s_err,
    output logic                   m_vld,
    output logic                   m_wen,
    output logic [AW-1:0]          m_adr,
    output logic [BW-1:0]          m_ben,
    output logic [DW-1:0]          m_wdt,
    input  logic                   m_rdy,
    input  logic [DW-1:0]          m_rdt,
    input  logic                   m_err
);
    localparam int unsigned SW = (PN > 1) ? $clog2(PN) : 1;

    typedef enum logic {ARB, LOCK} state_t;

    state_t                 state;
    logic [SW-1:0]          ptr;
    logic [SW-1:0]          own;
    logic [SW-1:0]          gnt;
    logic                   gnt_vld;
    logic                   xfer;
    logic [SW:0]            idx;
    logic [DLY-1:0]         vld_pipe;
    logic [DLY-1:0][SW-1:0] idx_pipe;

    // Scan from the far end back toward ptr so the last hit is the nearest one.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        if (state == LOCK) begin
            gnt     = own;
            gnt_vld = s_vld[own];
        end else begin
            for (int i = PN-1; i >= 0; i--) begin
                idx = {1'b0, ptr} + (SW+1)'(i);
                if (idx >= (SW+1)'(PN))
                    idx = idx - (SW+1)'(PN);
                if (s_vld[idx[SW-1:0]]) begin
                    gnt     = idx[SW-1:0];
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        m_vld = gnt_vld;
        m_wen = 1'b0;
        m_adr = '0;
        m_ben = '0;
        m_wdt = '0;
        if (gnt_vld) begin
            m_wen = s_wen[gnt];
            m_adr = s_adr[gnt];
            m_ben = s_ben[gnt];
            m_wdt = s_wdt[gnt];
        end
    end

    assign xfer = m_vld & m_rdy;

    // A locked transfer keeps ptr, so the rotation resumes where it left off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
            ptr   <= '0;
            own   <= '0;
        end else if (xfer) begin
            if (s_lck[gnt]) begin
                state <= LOCK;
                own   <= gnt;
            end else begin
                state <= ARB;
                ptr   <= (gnt == SW'(PN-1)) ? '0 : gnt + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            vld_pipe[0] <= xfer;
            idx_pipe[0] <= gnt;
            for (int s = 1; s < DLY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                idx_pipe[s] <= idx_pipe[s-1];
            end
        end
    end

    generate
        for (genvar i = 0; i < PN; i++) begin : g_lane
            tcb_arb_rr_lane #(.DW(DW)) u_lane (
                .sel_req (gnt_vld && (gnt == SW'(i))),
                .sel_rsp (vld_pipe[DLY-1] && (idx_pipe[DLY-1] == SW'(i))),
                .m_rdy   (m_rdy),
                .m_rdt   (m_rdt),
                .m_err   (m_err),
                .s_rdy   (s_rdy[i]),
                .s_rdt   (s_rdt[i]),
                .s_err   (s_err[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_tcb_arb_rr.sv
// Directed bench for tcb_arb_rr: one DUT with DLY=1 and one with DLY=3 share
// the stimulus; responses are tracked per DUT in a scoreboard queue.

module tb_tcb_arb_rr;
    localparam int PN = 3, AW = 32, DW = 32, BW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [PN-1:0]         s_vld, s_lck, s_wen;
    logic [PN-1:0][AW-1:0] s_adr;
    logic [PN-1:0][BW-1:0] s_ben;
    logic [PN-1:0][DW-1:0] s_wdt;
    logic                  m_rdy, m_err;
    logic [DW-1:0]         m_rdt;

    logic [PN-1:0]         rdy_a, err_a, rdy_b, err_b;
    logic [PN-1:0][DW-1:0] rdt_a, rdt_b;
    logic                  mv_a, mw_a, mv_b, mw_b;
    logic [AW-1:0]         ma_a, ma_b;
    logic [BW-1:0]         mb_a, mb_b;
    logic [DW-1:0]         md_a, md_b;

    tcb_arb_rr #(.AW(AW), .DW(DW), .BW(BW), .PN(PN), .DLY(1)) u_a (
        .clk(clk), .rst(rst),
        .s_vld(s_vld), .s_lck(s_lck), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben), .s_wdt(s_wdt),
        .s_rdy(rdy_a), .s_rdt(rdt_a), .s_err(err_a),
        .m_vld(mv_a), .m_wen(mw_a), .m_adr(ma_a), .m_ben(mb_a), .m_wdt(md_a),
        .m_rdy(m_rdy), .m_rdt(m_rdt), .m_err(m_err)
    );

    tcb_arb_rr #(.AW(AW), .DW(DW), .BW(BW), .PN(PN), .DLY(3)) u_b (
        .clk(clk), .rst(rst),
        .s_vld(s_vld), .s_lck(s_lck), .s_wen(s_wen), .s_adr(s_adr), .s_ben(s_ben), .s_wdt(s_wdt),
        .s_rdy(rdy_b), .s_rdt(rdt_b), .s_err(err_b),
        .m_vld(mv_b), .m_wen(mw_b), .m_adr(ma_b), .m_ben(mb_b), .m_wdt(md_b),
        .m_rdy(m_rdy), .m_rdt(m_rdt), .m_err(m_err)
    );

    typedef struct {
        int port;
        int due;
    } ent_t;

    ent_t qa[$];
    ent_t qb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cnt = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected response for this cycle: the scoreboard head, if it is due now.
    task automatic rsp_step(input int d, input logic [PN-1:0][DW-1:0] rdt,
                            input logic [PN-1:0] err, input string tag);
        logic [PN-1:0][DW-1:0] er;
        logic [PN-1:0]         ee;
        ent_t                  e;
        er = '0;
        ee = '0;
        if (d == 1) begin
            if (qa.size() > 0 && qa[0].due == cnt) begin
                e = qa.pop_front();
                er[e.port] = m_rdt;
                ee[e.port] = m_err;
            end
        end else begin
            if (qb.size() > 0 && qb[0].due == cnt) begin
                e = qb.pop_front();
                er[e.port] = m_rdt;
                ee[e.port] = m_err;
            end
        end
        chk({tag, "_rdt"}, 128'(rdt), 128'(er));
        chk({tag, "_err"}, 128'(err), 128'(ee));
    endtask

    // One clock: drive subordinate response, check at negedge, log transfers.
    task automatic cyc(input int g, input bit gv, input logic err);
        logic [PN-1:0] er;
        logic [127:0]  exq;
        ent_t          e;
        m_rdt = $urandom;
        m_err = err;
        @(negedge clk);
        er  = '0;
        exq = '0;
        if (gv) begin
            exq = 128'({1'b1, s_wen[g], s_ben[g], s_adr[g], s_wdt[g]});
            if (m_rdy) er[g] = 1'b1;
        end
        chk("req_a", 128'({mv_a, mw_a, mb_a, ma_a, md_a}), exq);
        chk("req_b", 128'({mv_b, mw_b, mb_b, ma_b, md_b}), exq);
        chk("rdy_a", 128'(rdy_a), 128'(er));
        chk("rdy_b", 128'(rdy_b), 128'(er));
        rsp_step(1, rdt_a, err_a, "a");
        rsp_step(3, rdt_b, err_b, "b");
        if (gv && m_rdy && !rst) begin
            e.port = g;
            e.due  = cnt + 1;
            qa.push_back(e);
            e.due  = cnt + 3;
            qb.push_back(e);
        end
        @(posedge clk);
        #1;
        cnt++;
    endtask

    initial begin
        rst   = 1'b1;
        s_vld = '0;
        s_lck = '0;
        s_wen = 3'b010;
        m_rdy = 1'b1;
        m_rdt = '0;
        m_err = 1'b0;
        for (int i = 0; i < PN; i++) begin
            s_adr[i] = 32'h1000 * (i + 1);
            s_ben[i] = 4'h1 << i;
            s_wdt[i] = 32'hA0 + i;
        end

        // reset: idle, then a combinational grant from ptr=0 that must not commit
        cyc(0, 0, 1'b0);
        s_vld = 3'b110;
        cyc(1, 1, 1'b0);
        rst = 1'b0;

        // all ports requesting: plain rotation
        s_vld = 3'b111;
        for (int i = 0; i < 6; i++) cyc(i % 3, 1, logic'(i % 2));

        // ptr=2 with ports 0 and 2 requesting; port 1 idle
        s_vld = 3'b010; cyc(1, 1, 1'b0);
        s_vld = 3'b101; cyc(2, 1, 1'b0); cyc(0, 1, 1'b0); cyc(2, 1, 1'b0);

        // port 1 locks for two transfers, unlocks on the third
        s_vld = 3'b001; cyc(0, 1, 1'b0);
        s_vld = 3'b111; s_lck = 3'b010;
        cyc(1, 1, 1'b0); cyc(1, 1, 1'b0);
        s_lck = 3'b000;
        cyc(1, 1, 1'b0); cyc(2, 1, 1'b0);

        // lock owner idle: nobody else may be granted
        s_vld = 3'b010; s_lck = 3'b010; cyc(1, 1, 1'b0);
        s_vld = 3'b101; s_lck = 3'b000; cyc(0, 0, 1'b0);
        s_vld = 3'b010; cyc(1, 1, 1'b0);

        // stall: port 0 keeps its grant while port 1 waits
        m_rdy = 1'b0;
        s_vld = 3'b001; cyc(0, 1, 1'b0);
        s_vld = 3'b011;
        for (int i = 0; i < 3; i++) cyc(0, 1, 1'b0);
        m_rdy = 1'b1; cyc(0, 1, 1'b0);
        s_vld = 3'b010; cyc(1, 1, 1'b0);

        // reset mid-lock with a response in flight
        s_vld = 3'b100; s_lck = 3'b100; cyc(2, 1, 1'b0);
        rst = 1'b1; s_vld = '0; s_lck = '0;
        qa.delete();
        qb.delete();
        cyc(0, 0, 1'b0);
        rst = 1'b0; s_vld = 3'b111;
        cyc(0, 1, 1'b0); cyc(1, 1, 1'b0);

        // alternate ports 0/2; subordinate flags error on the second transfer
        s_vld = 3'b001; cyc(0, 1, 1'b0);
        s_vld = 3'b100; cyc(2, 1, 1'b0);
        s_vld = 3'b001; cyc(0, 1, 1'b0);
        s_vld = 3'b100; cyc(2, 1, 1'b0);
        s_vld = 3'b000; cyc(0, 0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tcb_arb_rr.md
TCB_ARB_RR -- requirements
Module: tcb_arb_rr

Interface
REQ-001 The block SHALL be a round-robin TCB arbiter with transfer locking and fixed-latency response routing, sharing one subordinate among PN managers.
REQ-002 The block SHALL have these parameters:
- AW, default 32, address width.
- DW, default 32, data width.
- BW, default DW/8, byte-enable width.
- PN, default 3, number of manager ports (2..16).
- DLY, default 1, response latency in clock cycles (1..4).
REQ-003 The block SHALL have these ports (SW = $clog2(PN)):
- clk  in  1  clock; one clock domain, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- s_vld  in  PN  per-port request valid.
- s_lck  in  PN  per-port lock request; holds the grant after this transfer.
- s_wen  in  PN  per-port write enable.
- s_adr  in  PN*AW  per-port address.
- s_ben  in  PN*BW  per-port byte enable.
- s_wdt  in  PN*DW  per-port write data.
- s_rdy  out  PN  per-port ready.
- s_rdt  out  PN*DW  per-port read data.
- s_err  out  PN  per-port error.
- m_vld  out  1  request valid to the subordinate.
- m_wen  out  1  write enable.
- m_adr  out  AW  address.
- m_ben  out  BW  byte enable.
- m_wdt  out  DW  write data.
- m_rdy  in  1  subordinate ready.
- m_rdt  in  DW  subordinate read data.
- m_err  in  1  subordinate error.

Function
REQ-004 A transfer SHALL occur on any rising clk edge where m_vld & m_rdy.
REQ-005 FSM states SHALL be ARB and LOCK, with a registered SW-bit pointer ptr and a registered SW-bit owner own.
REQ-006 In ARB, the combinational grant g SHALL be the first index i with s_vld[i]=1, scanning ptr, ptr+1, ..., PN-1, 0, ..., ptr-1.
REQ-007 In LOCK, g SHALL equal own, and no other port SHALL be granted.
REQ-008 With a valid grant, m_vld/m_wen/m_adr/m_ben/m_wdt SHALL equal port g's request signals.
REQ-009 With no valid grant (ARB and s_vld=0, or LOCK and s_vld[own]=0), m_vld SHALL be 0 and the other m_* outputs SHALL be 0.
REQ-010 s_rdy[g] SHALL equal m_rdy combinationally, and s_rdy[i] for every i!=g SHALL be 0.
REQ-011 On a transfer from g with s_lck[g]=1, the state SHALL become LOCK with own<=g, and ptr SHALL be unchanged.
REQ-012 On a transfer from g with s_lck[g]=0, the state SHALL become ARB and ptr<=(g==PN-1)?0:g+1, wrapping at PN-1 (non-power-of-two PN included).
REQ-013 Without a transfer, state and ptr SHALL hold.
- A stalled request (m_rdy=0) keeps its grant because ptr is unchanged.
- The TCB rule that a manager holds its request stable until rdy is not checked by this block.
REQ-014 A DLY-stage shift register SHALL record {valid, g} for each cycle, with valid = transfer occurred.
REQ-015 When stage DLY-1 is valid with index k, s_rdt[k]=m_rdt and s_err[k]=m_err; all other ports, and all ports when that stage is invalid, SHALL see s_rdt=0 and s_err=0.
REQ-016 Back-to-back transfers from different ports SHALL route each response to its own port with no bubble.
REQ-017 The request path SHALL be combinational (zero added latency), and the response latency through the block SHALL be 0 beyond the subordinate's DLY.

Reset
REQ-018 While rst=1, the block SHALL hold:
- state=ARB, ptr=0, own=0;
- all response-stage valid bits=0;
- m_vld=0 and s_rdy=0 unless a combinational grant exists per REQ-006 with ptr=0;
- s_rdt=0, s_err=0.
REQ-019 Reset asserted mid-LOCK or mid-response SHALL cancel the lock and discard pending response routing immediately (asynchronously).

Verification
REQ-020 A bench with PN=3, DLY=1 SHALL cover at least these scenarios:
- All s_vld=1, s_lck=0, m_rdy=1 for 6 cycles -> grants 0,1,2,0,1,2; each s_rdt[k] = m_rdt one cycle after port k's transfer.
- s_vld=3'b101, ptr=2, m_rdy=1 -> grant 2, then 0, then 2; port 1 never sees rdy.
- Port 1 issues 3 transfers with s_lck=1,1,0 while ports 0 and 2 request -> port 1 gets 3 consecutive grants, then ptr=2 and port 2 is granted.
- Port 0 requests with m_rdy=0 for 4 cycles while port 1 raises vld -> grant stays 0 and s_rdy[1]=0; when m_rdy=1, port 0 transfers, then port 1 is granted.
- rst pulse while in LOCK with a response pending -> next cycle state=ARB, ptr=0, all s_rdt=0 and s_err=0.
- DLY=3, alternating ports 0 and 2 with m_err=1 on the second transfer -> s_err[2]=1 exactly 3 cycles after that transfer, and 0 on all other cycles and ports.
